// File: rtl/ext_csr_if_pkg.sv
// Shared types and register-map helpers for the external CSR error-counter bank.
// Register offsets are functions of the channel count, so they are exposed as helpers.
package ext_csr_if_pkg;

  typedef struct packed {
    logic [31:0] corr;
    logic [31:0] uncorr;
  } mc_err_cnt_t;

  typedef enum logic [0:0] {
    MC_ERR_CORR   = 1'b0,
    MC_ERR_UNCORR = 1'b1
  } mc_err_cnt_field_e;

  localparam int unsigned MC_ERR_REG_BYTES = 8;

  function automatic int unsigned mc_err_cnt_off(input int unsigned ch);
    return MC_ERR_REG_BYTES * ch;
  endfunction

  function automatic int unsigned mc_err_thresh_off(input int unsigned num_mc);
    return MC_ERR_REG_BYTES * num_mc;
  endfunction

  function automatic int unsigned mc_err_status_off(input int unsigned num_mc);
    return MC_ERR_REG_BYTES * num_mc + MC_ERR_REG_BYTES;
  endfunction

endpackage

// File: rtl/ext_csr_mc_err_cnt_bank_sat_cnt.sv
// ext_csr_sat_cnt: one saturating event counter with clear; clear+event yields 1.
// EXT_CSR_ERR_THRESH_IRQ_EN exposes the next-state value for threshold detection.
module ext_csr_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
`ifdef EXT_CSR_ERR_THRESH_IRQ_EN
  output logic [CNT_W-1:0] o_cnt_nxt,
`endif
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (i_clr)                          w_nxt = CNT_W'(i_inc);
    else if (i_inc && r_cnt != CNT_MAX) w_nxt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_nxt;
  end

  assign o_cnt = r_cnt;
`ifdef EXT_CSR_ERR_THRESH_IRQ_EN
  assign o_cnt_nxt = w_nxt;
`endif

endmodule

// File: rtl/ext_csr_mc_err_cnt_bank.sv
// Per-channel correctable/uncorrectable error counter bank on the external CSR interface.
// EXT_CSR_ERR_THRESH_IRQ_EN enables THRESH/STATUS registers and err_irq.
module ext_csr_mc_err_cnt_bank
  import ext_csr_if_pkg::*;
#(
  parameter int                NUM_MC    = 2,
  parameter int                CNT_W     = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_MC-1:0] mc_corr_err,
  input  logic [NUM_MC-1:0] mc_uncorr_err,
  input  logic              csr_req_valid,
  input  logic              csr_req_wr,
  input  logic [ADDR_W-1:0] csr_req_addr,
  input  logic [63:0]       csr_req_wdata,
  output logic              csr_rsp_valid,
  output logic [63:0]       csr_rsp_data,
  output logic              csr_rsp_err,
  output logic              err_irq
);

  localparam logic [ADDR_W-1:0] THR_OFF = ADDR_W'(mc_err_thresh_off(NUM_MC));
  localparam logic [ADDR_W-1:0] STS_OFF = ADDR_W'(mc_err_status_off(NUM_MC));

  logic [ADDR_W-1:0]               w_off;
  logic [NUM_MC-1:0]               w_hit_cnt;
  logic                            w_hit_thr, w_hit_sts, w_in_map, w_wr, w_rd;
  logic [1:0][NUM_MC-1:0]          w_evt, w_clr, w_sts;
  logic [1:0][NUM_MC-1:0][CNT_W-1:0] w_cnt;
  mc_err_cnt_t [NUM_MC-1:0]        w_chan;
  logic [63:0]                     w_thr, w_rd_data;
  logic                            r_rsp_valid, r_rsp_err;
  logic [63:0]                     r_rsp_data;

  // Full-offset compares make misaligned addresses miss every register.
  assign w_off     = csr_req_addr - BASE_ADDR;
  assign w_hit_thr = (w_off == THR_OFF);
  assign w_hit_sts = (w_off == STS_OFF);
  assign w_in_map  = (|w_hit_cnt) | w_hit_thr | w_hit_sts;
  assign w_wr      = csr_req_valid & csr_req_wr;
  assign w_rd      = csr_req_valid & ~csr_req_wr;

  assign w_evt[MC_ERR_CORR]   = mc_corr_err;
  assign w_evt[MC_ERR_UNCORR] = mc_uncorr_err;
  assign w_clr[MC_ERR_CORR]   = w_hit_cnt & {NUM_MC{w_wr && (csr_req_wdata[63:32] != '0)}};
  assign w_clr[MC_ERR_UNCORR] = w_hit_cnt & {NUM_MC{w_wr && (csr_req_wdata[31:0] != '0)}};

`ifdef EXT_CSR_ERR_THRESH_IRQ_EN
  logic [1:0][NUM_MC-1:0][CNT_W-1:0] w_cnt_nxt;
`endif

  for (genvar ch = 0; ch < NUM_MC; ch++) begin : g_ch
    assign w_hit_cnt[ch] = (w_off == ADDR_W'(mc_err_cnt_off(ch)));
    for (genvar f = 0; f < 2; f++) begin : g_fld
      ext_csr_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_inc     (w_evt[f][ch]),
        .i_clr     (w_clr[f][ch]),
`ifdef EXT_CSR_ERR_THRESH_IRQ_EN
        .o_cnt_nxt (w_cnt_nxt[f][ch]),
`endif
        .o_cnt     (w_cnt[f][ch])
      );
    end
    assign w_chan[ch].corr   = 32'(w_cnt[MC_ERR_CORR][ch]);
    assign w_chan[ch].uncorr = 32'(w_cnt[MC_ERR_UNCORR][ch]);
  end

`ifdef EXT_CSR_ERR_THRESH_IRQ_EN
  logic [63:0]            r_thr;
  logic [1:0][NUM_MC-1:0] r_sts, w_sts_set, w_sts_w1c;
  logic [1:0][31:0]       w_thr_f;
  logic                   r_irq;

  assign w_thr_f[MC_ERR_CORR]     = r_thr[63:32];
  assign w_thr_f[MC_ERR_UNCORR]   = r_thr[31:0];
  assign w_sts_w1c[MC_ERR_CORR]   = csr_req_wdata[NUM_MC-1:0] & {NUM_MC{w_wr & w_hit_sts}};
  assign w_sts_w1c[MC_ERR_UNCORR] = csr_req_wdata[32 +: NUM_MC] & {NUM_MC{w_wr & w_hit_sts}};

  // Only an event can set a bit, so a W1C sticks while the count sits above threshold.
  for (genvar f = 0; f < 2; f++) begin : g_thr
    for (genvar ch = 0; ch < NUM_MC; ch++) begin : g_ch
      assign w_sts_set[f][ch] = w_evt[f][ch] && (w_thr_f[f] != '0) &&
                                (32'(w_cnt_nxt[f][ch]) >= w_thr_f[f]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr <= '0;
      r_sts <= '0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr && w_hit_thr) r_thr <= csr_req_wdata;
      r_sts <= (r_sts & ~w_sts_w1c) | w_sts_set;
      r_irq <= |r_sts;
    end
  end

  assign w_thr   = r_thr;
  assign w_sts   = r_sts;
  assign err_irq = r_irq;
`else
  assign w_thr   = '0;
  assign w_sts   = '0;
  assign err_irq = 1'b0;
`endif

  always_comb begin
    w_rd_data = '0;
    for (int ch = 0; ch < NUM_MC; ch++)
      if (w_hit_cnt[ch]) w_rd_data = w_chan[ch];
    if (w_hit_thr) w_rd_data = w_thr;
    if (w_hit_sts) begin
      w_rd_data[NUM_MC-1:0]  = w_sts[MC_ERR_CORR];
      w_rd_data[32 +: NUM_MC] = w_sts[MC_ERR_UNCORR];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= csr_req_valid;
      r_rsp_err   <= csr_req_valid & ~w_in_map;
      r_rsp_data  <= (w_rd && w_in_map) ? w_rd_data : '0;
    end
  end

  assign csr_rsp_valid = r_rsp_valid;
  assign csr_rsp_err   = r_rsp_err;
  assign csr_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_ext_csr_mc_err_cnt_bank.sv
// Bench for ext_csr_mc_err_cnt_bank: directed steps plus random traffic against a
// register-level reference model; follows EXT_CSR_ERR_THRESH_IRQ_EN when defined.
module tb_ext_csr_mc_err_cnt_bank;

  localparam int          NUM_MC  = 2;
  localparam int          CNT_W   = 4;
  localparam int          ADDR_W  = 32;
  localparam logic [31:0] BASE    = 32'h0000_1000;
  localparam int unsigned CMAX    = (1 << CNT_W) - 1;
  localparam int          MAP_END = 8 * NUM_MC + 16;
`ifdef EXT_CSR_ERR_THRESH_IRQ_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NUM_MC-1:0] mc_corr_err = '0, mc_uncorr_err = '0;
  logic              csr_req_valid = 1'b0, csr_req_wr = 1'b0;
  logic [ADDR_W-1:0] csr_req_addr = '0;
  logic [63:0]       csr_req_wdata = '0;
  logic              csr_rsp_valid, csr_rsp_err, err_irq;
  logic [63:0]       csr_rsp_data;

  ext_csr_mc_err_cnt_bank #(
    .NUM_MC(NUM_MC), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mc_corr_err(mc_corr_err), .mc_uncorr_err(mc_uncorr_err),
    .csr_req_valid(csr_req_valid), .csr_req_wr(csr_req_wr),
    .csr_req_addr(csr_req_addr), .csr_req_wdata(csr_req_wdata),
    .csr_rsp_valid(csr_rsp_valid), .csr_rsp_data(csr_rsp_data),
    .csr_rsp_err(csr_rsp_err), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: architectural register contents only.
  int unsigned       m_corr[NUM_MC], m_unc[NUM_MC];
  logic [63:0]       m_thr;
  logic [NUM_MC-1:0] m_sc, m_su;

  task automatic m_reset();
    for (int c = 0; c < NUM_MC; c++) begin m_corr[c] = 0; m_unc[c] = 0; end
    m_thr = '0; m_sc = '0; m_su = '0;
  endtask

  function automatic logic [63:0] m_read(input int off);
    logic [63:0] v;
    int idx;
    idx = off / 8;
    v = '0;
    if (idx < NUM_MC) v = {m_corr[idx], m_unc[idx]};
    else if (idx == NUM_MC) v = THR_EN ? m_thr : 64'd0;
    else if (THR_EN) begin v[NUM_MC-1:0] = m_sc; v[32 +: NUM_MC] = m_su; end
    return v;
  endfunction

  function automatic int unsigned bump(input int unsigned c, input bit ev, input bit clr);
    if (clr) return ev ? 1 : 0;
    if (ev)  return (c < CMAX) ? c + 1 : CMAX;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive a request/pulses, advance the model, check the response.
  task automatic step(input logic [NUM_MC-1:0] ce, input logic [NUM_MC-1:0] ue,
                      input bit rv, input bit wr, input int off, input logic [63:0] wd);
    bit bad, hit, irq_e;
    int idx;
    logic [63:0] ed;
    logic [NUM_MC-1:0] set_c, set_u, w1c_c, w1c_u;
    int unsigned nc, nu;
    mc_corr_err = ce; mc_uncorr_err = ue;
    csr_req_valid = rv; csr_req_wr = wr;
    csr_req_addr = BASE + 32'(off); csr_req_wdata = wd;
    @(posedge clk);
    bad   = (off < 0) || (off % 8 != 0) || (off >= MAP_END);
    idx   = bad ? -1 : off / 8;
    hit   = rv && wr && !bad;
    ed    = (rv && !wr && !bad) ? m_read(off) : 64'd0;
    irq_e = THR_EN && ((m_sc | m_su) != '0);
    set_c = '0; set_u = '0; w1c_c = '0; w1c_u = '0;
    for (int c = 0; c < NUM_MC; c++) begin
      nc = bump(m_corr[c], ce[c], hit && idx == c && wd[63:32] != 32'd0);
      nu = bump(m_unc[c],  ue[c], hit && idx == c && wd[31:0]  != 32'd0);
      if (THR_EN && ce[c] && m_thr[63:32] != 0 && nc >= m_thr[63:32]) set_c[c] = 1'b1;
      if (THR_EN && ue[c] && m_thr[31:0]  != 0 && nu >= m_thr[31:0])  set_u[c] = 1'b1;
      m_corr[c] = nc; m_unc[c] = nu;
    end
    if (THR_EN && hit && idx == NUM_MC + 1) begin
      w1c_c = wd[NUM_MC-1:0]; w1c_u = wd[32 +: NUM_MC];
    end
    m_sc = (m_sc & ~w1c_c) | set_c;
    m_su = (m_su & ~w1c_u) | set_u;
    if (THR_EN && hit && idx == NUM_MC) m_thr = wd;
    #1;
    mc_corr_err = '0; mc_uncorr_err = '0; csr_req_valid = 1'b0; csr_req_wr = 1'b0;
    chk("rsp_valid", 64'(csr_rsp_valid), 64'(rv));
    if (rv) begin
      chk("rsp_data", csr_rsp_data, ed);
      chk("rsp_err", 64'(csr_rsp_err), 64'(bad));
    end
    chk("err_irq", 64'(err_irq), 64'(irq_e));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic rd(input int off);
    step('0, '0, 1'b1, 1'b0, off, '0);
  endtask

  task automatic wr(input int off, input logic [63:0] d);
    step('0, '0, 1'b1, 1'b1, off, d);
  endtask

  initial begin
    int offs[9];
    offs = '{0, 8, 16, 24, 4, 32, -8, 12, 40};
    m_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(csr_rsp_valid), 64'd0);
    chk("reset_data",  csr_rsp_data, 64'd0);
    chk("reset_err",   64'(csr_rsp_err), 64'd0);
    chk("reset_irq",   64'(err_irq), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    rd(0); rd(8); rd(8 * NUM_MC);

    // Saturation on ch1 correctable
    for (int i = 0; i < 20; i++) step(2'b10, '0, 1'b0, 1'b0, 0, '0);
    rd(8);
    chk("sat_lit", csr_rsp_data, 64'h0000_000F_0000_0000);
    idle(1);

    // Clear and event in the same cycle
    for (int i = 0; i < 5; i++) step('0, 2'b01, 1'b0, 1'b0, 0, '0);
    rd(0);
    chk("pre_clr_lit", csr_rsp_data, 64'h0000_0000_0000_0005);
    step('0, 2'b01, 1'b1, 1'b1, 0, 64'h0000_0000_0000_0001);
    rd(0);
    chk("clr_evt_lit", csr_rsp_data, 64'h0000_0000_0000_0001);

    // Bad addresses, then counters unchanged
    rd(8 * NUM_MC + 16);
    chk("bad_hi_err", 64'(csr_rsp_err), 64'd1);
    rd(4);
    chk("bad_mis_err", 64'(csr_rsp_err), 64'd1);
    step('0, '0, 1'b1, 1'b1, 4, '1);
    rd(0); rd(8);

    // Threshold on ch0 correctable
    wr(8 * NUM_MC, 64'h0000_0003_0000_0000);
    for (int i = 0; i < 3; i++) step(2'b01, '0, 1'b0, 1'b0, 0, '0);
    rd(8 * NUM_MC + 8);
    chk("sts_lit", csr_rsp_data, THR_EN ? 64'h1 : 64'h0);
    chk("irq_lit", 64'(err_irq), 64'(THR_EN));
    wr(8 * NUM_MC + 8, 64'h1);
    idle(2);
    chk("irq_clr_lit", 64'(err_irq), 64'd0);

    // THRESH all-ones, then a burst of events
    wr(8 * NUM_MC, '1);
    rd(8 * NUM_MC);
    chk("thr_rd_lit", csr_rsp_data, THR_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
    for (int i = 0; i < 10; i++) step(2'b11, 2'b11, 1'b0, 1'b0, 0, '0);
    idle(1);
    chk("irq_quiet_lit", 64'(err_irq), 64'd0);
    wr(8 * NUM_MC, 64'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] hi, lo;
      int sel;
      sel = $urandom_range(0, 2);
      hi  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      sel = $urandom_range(0, 2);
      lo  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      step(NUM_MC'($urandom), NUM_MC'($urandom), $urandom_range(0, 2) != 0,
           1'($urandom_range(0, 1)), offs[$urandom_range(0, 8)], {hi, lo});
    end

    // Async reset in the middle of a burst
    for (int i = 0; i < 4; i++) step(2'b11, 2'b11, 1'b1, 1'b0, 0, '0);
    mc_corr_err = '1; mc_uncorr_err = '1;
    csr_req_valid = 1'b1; csr_req_wr = 1'b0; csr_req_addr = BASE;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(csr_rsp_valid), 64'd0);
    chk("mid_rst_data",  csr_rsp_data, 64'd0);
    chk("mid_rst_irq",   64'(err_irq), 64'd0);
    mc_corr_err = '0; mc_uncorr_err = '0; csr_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    m_reset();
    idle(2);
    rd(0);
    chk("post_rst_ch0", csr_rsp_data, 64'd0);
    rd(8);
    chk("post_rst_ch1", csr_rsp_data, 64'd0);
    rd(8 * NUM_MC + 8);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_csr_mc_err_cnt_bank.md
# ext_csr_mc_err_cnt_bank

Parametrised bank of memory-controller error counters exposed on the external CSR request/response interface of the CAFU CSR space. For each of `NUM_MC` memory-controller channels it accumulates correctable and uncorrectable error events in saturating counters. Software reads the counters as `mc_err_cnt_t`-formatted 64-bit words and clears them per field. Optionally, per-field threshold detection raises an interrupt.

## Interface
Parameters:
- `NUM_MC`, 2: number of memory-controller channels, 1..8.
- `CNT_W`, 32: counter width, 1..32; zero-extended into each 32-bit field.
- `ADDR_W`, 32: CSR address width.
- `BASE_ADDR`, 32'h0: byte address of channel 0 counter register; 8-byte aligned.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mc_corr_err` in NUM_MC: one-cycle pulse per correctable error, per channel.
- `mc_uncorr_err` in NUM_MC: one-cycle pulse per uncorrectable error, per channel.
- `csr_req_valid` in 1: request strobe, one cycle per request.
- `csr_req_wr` in 1: 1 = write, 0 = read.
- `csr_req_addr` in ADDR_W: byte address.
- `csr_req_wdata` in 64: write data.
- `csr_rsp_valid` out 1: response strobe.
- `csr_rsp_data` out 64: read data; 0 for writes.
- `csr_rsp_err` out 1: address outside the map.
- `err_irq` out 1: level interrupt.

## Operation
- Register map (offset from `BASE_ADDR`):
  - `8*ch`: channel counter register, `{correctable[63:32], uncorrectable[31:0]}`.
  - `8*NUM_MC`: THRESH register, `{corr_thresh[63:32], uncorr_thresh[31:0]}`.
  - `8*NUM_MC+8`: STATUS register. Bit `ch` = correctable threshold hit; bit `32+ch` = uncorrectable threshold hit. W1C.
- Counter register write:
  - A nonzero upper half clears the correctable counter.
  - A nonzero lower half clears the uncorrectable counter.
  - Other write values are ignored.
- Counters:
  - +1 per event pulse.
  - Saturate at `2**CNT_W-1` and hold until cleared.
- Clear and event in the same cycle: the counter becomes 1, so the event is never lost.
- Reads sample register state at the request cycle, before any same-cycle increment or clear takes effect.
- Address handling:
  - Misaligned addresses (bits [2:0] != 0) and addresses outside the map produce `csr_rsp_err`=1 and data 0.
  - Such requests have no side effects.
- Every request is accepted; there is no backpressure.

## Timing
- Reset values: all counters 0, THRESH 0, STATUS 0, `csr_rsp_valid` 0, `csr_rsp_data` 0, `csr_rsp_err` 0, `err_irq` 0.
- Response latency: exactly 1 cycle. A request in cycle N gives `csr_rsp_valid` high in N+1 for one cycle.
- Back-to-back requests every cycle are supported. A write in N is visible to a read in N+1.
- Counter updates land in the cycle after the event pulse.
- Reset mid-operation: all state clears immediately. No response is issued for a request in flight.

## Configuration
- `EXT_CSR_ERR_THRESH_IRQ_EN` defined:
  - A STATUS bit sets when its counter's next value is ≥ its threshold and the threshold is nonzero.
  - The bit remains set until written with 1. Set wins over a same-cycle W1C.
  - `err_irq` = registered OR of STATUS, so it rises one cycle after the STATUS bit sets.
- Undefined:
  - THRESH and STATUS read as 0; writes to them are ignored and produce no error.
  - `err_irq` is tied to 0.
  - Ports and register map are unchanged.

## Structure
- `ext_csr_if_pkg` gains register offset constants for the counter, THRESH and STATUS registers.
- `ext_csr_if_pkg` also gains a `mc_err_cnt_field_e` enum (CORR, UNCORR).
- Channel data is packed with the existing `mc_err_cnt_t` layout.
- Sub-module `ext_csr_sat_cnt`: one saturating counter with increment, clear and clear-plus-increment behaviour. It is instantiated `2*NUM_MC` times.

## Test plan
- Saturation: `CNT_W`=4; 20 correctable pulses on ch1 → read `8*1` returns 64'h0000_000F_0000_0000; `csr_rsp_valid` is high exactly 1 cycle after the request.
- Simultaneous clear and event:
  - Setup: ch0 uncorrectable = 5.
  - Stimulus: write 64'h0000_0000_0000_0001 to offset 0 in the same cycle as an uncorrectable pulse.
  - Response: the next read returns 64'h0000_0000_0000_0001.
- Bad address: read at offset `8*NUM_MC+16` → `csr_rsp_err`=1, data 0; read at offset 4 → `csr_rsp_err`=1, data 0; no counter changes.
- Threshold, with macro defined:
  - Setup: THRESH = 64'h0000_0003_0000_0000.
  - Stimulus: 3 correctable pulses on ch0.
  - Response: STATUS bit 0 = 1 and `err_irq` = 1.
  - Then write STATUS 64'h1 → `err_irq` = 0 two cycles later.
- Macro undefined: write THRESH 64'hFFFF_FFFF_FFFF_FFFF → read returns 0, `err_irq` stays 0 after 10 pulses.
- Async reset: assert `rst_n` low mid-burst → all counters read 0 after release and no stale `csr_rsp_valid` appears.
